// File: rtl/mem_io_responder.sv
// Memory-side responder: 128 KB RAM, UART TX FIFO / RX port,
// free-running cycle counter with snapshot, and program-stop latch.
module mem_io_responder #(
    parameter int    ADDR_WIDTH   = 17,
    parameter int    TX_DEPTH_LOG = 3,
    parameter string INIT_FILE    = ""
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop
);

    localparam int CW    = TX_DEPTH_LOG + 1;
    localparam int DEPTH = 1 << TX_DEPTH_LOG;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_MARK = CW'(DEPTH - 2);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [TX_DEPTH_LOG-1:0] PTR_ONE = TX_DEPTH_LOG'(1);

    logic [7:0] ram [0:(1 << ADDR_WIDTH) - 1];

    logic [17:0] addr;
    logic [15:0] off;
    logic        is_ram;
    logic        is_io;
    logic        wr_en;
    logic        rd_rx;
    logic        rd_cnt;
    logic        push;
    logic        push_ok;
    logic        pop;
    logic [7:0]  push_byte;
    logic        unused_addr_hi;

    logic [31:0] counter;
    logic [31:0] snap;

    logic [7:0]              fifo [0:DEPTH-1];
    logic [TX_DEPTH_LOG-1:0] rd_ptr;
    logic [TX_DEPTH_LOG-1:0] wr_ptr;
    logic [CW-1:0]           count;

    assign addr           = mem_a[17:0];
    assign off            = addr[15:0];
    assign unused_addr_hi = ^mem_a[31:18];
    assign is_ram         = ~addr[17];
    assign is_io          = (addr[17:16] == 2'b11);

    // Writes are blocked once the program has stopped.
    assign wr_en  = mem_wr & ~program_stop & ~rst_in;
    assign rd_rx  = is_io & ~mem_wr & (off == 16'h0000);
    assign rd_cnt = is_io & ~mem_wr & (off == 16'h0004);

    assign rx_ready = rd_rx & rx_valid & ~rst_in;

    // Stop write emits a 0x00 marker; byte writes drop zeros.
    always_comb begin
        push      = 1'b0;
        push_byte = mem_dout;
        if (wr_en && is_io) begin
            if (off == 16'h0004) begin
                push      = 1'b1;
                push_byte = 8'h00;
            end else if (off == 16'h0000) begin
                push = (mem_dout != 8'h00);
            end
        end
    end

    assign tx_valid = (count != '0);
    assign tx_data  = fifo[rd_ptr];
    assign pop      = tx_valid & tx_ready;
    assign push_ok  = push & ((count != DEPTH_C) | pop);

    // RAM write port; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (wr_en && is_ram) ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
    end

    // Registered read data; held across write cycles.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din <= 8'h00;
        end else if (!mem_wr) begin
            unique case (1'b1)
                is_ram: mem_din <= ram[mem_a[ADDR_WIDTH-1:0]];
                is_io: begin
                    unique case (off)
                        16'h0000: mem_din <= rx_valid ? rx_data : 8'h00;
                        16'h0004: mem_din <= counter[7:0];
                        16'h0005: mem_din <= snap[15:8];
                        16'h0006: mem_din <= snap[23:16];
                        16'h0007: mem_din <= snap[31:24];
                        default:  mem_din <= 8'h00;
                    endcase
                end
                default: mem_din <= 8'h00;
            endcase
        end
    end

    // Cycle counter, snapshot on low-byte read, and stop latch.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            counter      <= 32'd0;
            snap         <= 32'd0;
            program_stop <= 1'b0;
        end else begin
            if (!program_stop) counter <= counter + 32'd1;
            if (rd_cnt) snap <= counter;
            if (wr_en && is_io && off == 16'h0004) program_stop <= 1'b1;
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clk_in) begin
        if (push_ok) fifo[wr_ptr] <= push_byte;
    end

    // TX FIFO pointers, occupancy and lagged almost-full flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            io_buffer_full <= (count >= FULL_MARK);
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with read/TX scoreboards.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_stop;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rdq [$];
    logic [7:0]  txq [$];
    logic [31:0] mcnt;
    logic        mstop;
    logic [31:0] s;

    mem_io_responder dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .mem_a(mem_a),
        .mem_wr(mem_wr),
        .mem_dout(mem_dout),
        .mem_din(mem_din),
        .io_buffer_full(io_buffer_full),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .program_stop(program_stop)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle; reads push their expected byte, popped after the edge.
    task automatic bus(input logic [31:0] a, input logic w,
                       input logic [7:0] d, input bit rd,
                       input logic [7:0] e);
        logic exp_rr;
        mem_a    = a;
        mem_wr   = w;
        mem_dout = d;
        #1;
        exp_rr = !rst_in && !w && a[17:0] == 18'h30000 && rx_valid;
        chk("rx_ready", {31'd0, rx_ready}, {31'd0, exp_rr});
        if (rd) rdq.push_back(e);
        @(posedge clk_in);
        if (rst_in) begin
            mcnt  = 32'd0;
            mstop = 1'b0;
        end else begin
            if (!mstop) mcnt = mcnt + 32'd1;
            if (w && a[17:0] == 18'h30004) mstop = 1'b1;
        end
        #1;
        if (rd) chk("mem_din", {24'd0, mem_din}, {24'd0, rdq.pop_front()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(32'h20000, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // TX scoreboard: every accepted byte must match the next expected one.
    always @(negedge clk_in) begin
        if (!rst_in && tx_valid && tx_ready) begin
            checks++;
            assert (txq.size() != 0) else begin
                errors++;
                $error("FAIL tx_extra observed=%0h expected=none", tx_data);
            end
            if (txq.size() != 0) begin
                checks++;
                assert (tx_data === txq[0]) else begin
                    errors++;
                    $error("FAIL tx_data observed=%0h expected=%0h",
                           tx_data, txq[0]);
                end
                void'(txq.pop_front());
            end
        end
    end

    initial begin
        rst_in   = 1'b1;
        mem_a    = 32'h20000;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        mcnt     = 32'd0;
        mstop    = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_mem_din", {24'd0, mem_din}, 32'h0);
        chk("rst_io_full", {31'd0, io_buffer_full}, 32'h0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
        chk("rst_stop", {31'd0, program_stop}, 32'h0);
        rst_in = 1'b0;

        // RAM write/read-after-write, top byte, unmapped read
        bus(32'h00010, 1'b1, 8'hA5, 1'b0, 8'h00);
        bus(32'h00010, 1'b0, 8'h00, 1'b1, 8'hA5);
        bus(32'h1FFFF, 1'b1, 8'h5A, 1'b0, 8'h00);
        bus(32'h1FFFF, 1'b0, 8'h00, 1'b1, 8'h5A);
        bus(32'h20000, 1'b1, 8'h77, 1'b0, 8'h00);
        bus(32'h20000, 1'b0, 8'h00, 1'b1, 8'h00);
        bus(32'h00010, 1'b0, 8'h00, 1'b1, 8'hA5);

        // TX with zero filter
        tx_ready = 1'b1;
        txq.push_back(8'h48);
        bus(32'h30000, 1'b1, 8'h48, 1'b0, 8'h00);
        txq.push_back(8'h69);
        bus(32'h30000, 1'b1, 8'h69, 1'b0, 8'h00);
        bus(32'h30000, 1'b1, 8'h00, 1'b0, 8'h00);
        idle(4);
        chk("tx_zero_q", txq.size(), 32'd0);
        chk("tx_idle", {31'd0, tx_valid}, 32'h0);

        // Fill, almost-full timing, overflow drop, drain
        tx_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            txq.push_back(8'(k * 16 + k));
            bus(32'h30000, 1'b1, 8'(k * 16 + k), 1'b0, 8'h00);
            chk("io_full", {31'd0, io_buffer_full}, {31'd0, k >= 7});
        end
        bus(32'h30000, 1'b1, 8'hEE, 1'b0, 8'h00);
        chk("io_full_hold", {31'd0, io_buffer_full}, 32'h1);
        tx_ready = 1'b1;
        idle(12);
        chk("drain_q", txq.size(), 32'd0);
        chk("drain_valid", {31'd0, tx_valid}, 32'h0);
        chk("drain_full", {31'd0, io_buffer_full}, 32'h0);

        // RX port
        rx_valid = 1'b1;
        rx_data  = 8'h37;
        bus(32'h30000, 1'b0, 8'h00, 1'b1, 8'h37);
        bus(32'h00010, 1'b0, 8'h00, 1'b1, 8'hA5);
        rx_valid = 1'b0;
        bus(32'h30000, 1'b0, 8'h00, 1'b1, 8'h00);

        // Counter snapshot
        while (mcnt < 32'd300) idle(1);
        s = mcnt;
        bus(32'h30004, 1'b0, 8'h00, 1'b1, s[7:0]);
        bus(32'h30005, 1'b0, 8'h00, 1'b1, s[15:8]);
        bus(32'h30006, 1'b0, 8'h00, 1'b1, s[23:16]);
        bus(32'h30007, 1'b0, 8'h00, 1'b1, s[31:24]);
        idle(3);
        bus(32'h30005, 1'b0, 8'h00, 1'b1, s[15:8]);
        bus(32'h30003, 1'b0, 8'h00, 1'b1, 8'h00);

        // Program stop
        txq.push_back(8'h00);
        bus(32'h30004, 1'b1, 8'h99, 1'b0, 8'h00);
        chk("stop_set", {31'd0, program_stop}, 32'h1);
        s = mcnt;
        bus(32'h30004, 1'b0, 8'h00, 1'b1, s[7:0]);
        idle(5);
        bus(32'h30004, 1'b0, 8'h00, 1'b1, s[7:0]);
        bus(32'h00010, 1'b1, 8'h3C, 1'b0, 8'h00);
        bus(32'h00010, 1'b0, 8'h00, 1'b1, 8'hA5);
        bus(32'h30000, 1'b1, 8'h55, 1'b0, 8'h00);
        idle(4);
        chk("stop_q", txq.size(), 32'd0);
        chk("stop_hold", {31'd0, program_stop}, 32'h1);

        // Reset mid-operation
        rst_in = 1'b1;
        bus(32'h00010, 1'b0, 8'h00, 1'b1, 8'h00);
        rst_in = 1'b0;
        chk("rst2_stop", {31'd0, program_stop}, 32'h0);
        chk("rst2_tx_valid", {31'd0, tx_valid}, 32'h0);
        bus(32'h00010, 1'b0, 8'h00, 1'b1, 8'hA5);
        idle(2);
        s = mcnt;
        bus(32'h30004, 1'b0, 8'h00, 1'b1, s[7:0]);
        chk("rst2_cnt", s, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
